// File: rtl/upx1_bus_pkg.sv
// upx1_bus_pkg: shared constants and helpers for the uPx1 bus arbitration blocks.
package upx1_bus_pkg;

    // Upper bound on the number of arbitrated channels.
    localparam int MAX_CH = 16;

    // Ceiling log2 with a floor of 1, so a select field is never zero width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Reset value of the round-robin pointer: the last channel, so channel 0
    // is first in line after reset.
    function automatic int rr_ptr_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with optional lock override.
// The search starts one past ptr and wraps; a valid lock pins the grant to lock_idx.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            lock_vld,
    input  logic [SELW-1:0] lock_idx,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    logic w_found;

    // Pick the first requester above ptr, then wrap to the lowest at or below ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        if (lock_vld) begin
            // Locked: only the owner may be granted, and only while it requests.
            for (int i = 0; i < N; i++) begin
                if (int'(lock_idx) == i) grant[i] = req[i];
            end
            grant_idx = lock_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && req[i] && (i > int'(ptr))) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                    w_found   = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!w_found && req[i] && (i <= int'(ptr))) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                    w_found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-input W-bit round-robin arbitrated mux with valid/ready on
// both sides and a registered output stage (1 word/cycle, 1 cycle latency).
// Optional grant locking is compiled in with the macro MUX_ARB_LOCK_EN.
module mux_arb_nto1
    import upx1_bus_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N-1:0]    in_lock,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_sel
);

    localparam logic [SELW-1:0] RR_PTR_RST = SELW'(rr_ptr_rst(N));

    logic [SELW-1:0] r_ptr;
    logic            w_load_en;
    logic            w_xfer;
    logic [N-1:0]    w_grant;
    logic [SELW-1:0] w_grant_idx;
    logic [W-1:0]    w_data;
    logic            w_lock_vld;
    logic [SELW-1:0] w_lock_idx;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .lock_vld  (w_lock_vld),
        .lock_idx  (w_lock_idx),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // The output register can take a word when empty or being drained this cycle.
    assign w_load_en = !out_valid || out_ready;
    assign in_ready  = rst ? '0 : (w_grant & {N{w_load_en}});
    assign w_xfer    = |(in_valid & in_ready);

    // AND-OR select of the granted channel's data (grant is one-hot or zero).
    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            w_data = w_data | (in_data[W*i +: W] & {W{w_grant[i]}});
        end
    end

    // Output register and round-robin pointer; a plain drain keeps data/sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            r_ptr     <= RR_PTR_RST;
        end else if (w_xfer) begin
            out_valid <= 1'b1;
            out_data  <= w_data;
            out_sel   <= w_grant_idx;
            r_ptr     <= w_grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    logic            r_lock_vld;
    logic [SELW-1:0] r_lock_idx;

    // Each beat from the granted channel re-evaluates its lock request; the
    // unlocking beat itself is still granted to the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_xfer) begin
            r_lock_vld <= |(in_lock & w_grant);
            r_lock_idx <= w_grant_idx;
        end
    end

    assign w_lock_vld = r_lock_vld;
    assign w_lock_idx = r_lock_idx;
`else
    assign w_lock_vld = 1'b0;
    assign w_lock_idx = '0;
`endif

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: directed self-checking bench for mux_arb_nto1 (N=4, W=8,
// channel k carries 8'hA0+k). Lock scenario is built only with MUX_ARB_LOCK_EN.
module tb_mux_arb_nto1;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_lock;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_arb_nto1 #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MUX_ARB_LOCK_EN
        .in_lock   (in_lock),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_lock = '0;
        tick(); tick();
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL rst_in_ready got=%h exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        total++; if (out_sel !== 2'd0) begin bad++; $display("FAIL rst_out_sel got=%0d exp=0", out_sel); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=0001", in_ready); end
    endtask

    task automatic test_back_to_back();
        in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, out_valid); end
            total++; if (out_sel !== 2'(k % 4)) begin bad++; $display("FAIL b2b_sel[%0d] got=%0d exp=%0d", k, out_sel, k % 4); end
            total++; if (out_data !== 8'(8'hA0 + k % 4)) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, out_data, 8'(8'hA0 + k % 4)); end
        end
    endtask

    task automatic test_backpressure();
        // Held word is ch0 / A0; stall three cycles.
        out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL bp_in_ready0 got=%b exp=0000", in_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0000", k, in_ready); end
            total++; if (out_sel !== 2'd0 || out_data !== 8'hA0 || out_valid !== 1'b1)
                begin bad++; $display("FAIL bp_hold[%0d] got sel=%0d data=%h v=%b exp sel=0 data=a0 v=1", k, out_sel, out_data, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
        tick();
        total++; if (out_sel !== 2'd1 || out_data !== 8'hA1) begin bad++; $display("FAIL bp_release got sel=%0d data=%h exp sel=1 data=a1", out_sel, out_data); end
    endtask

    task automatic test_single_channel();
        in_valid = 4'b0100; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL single_ready[%0d] got=%b exp=0100", k, in_ready); end
            tick();
            total++; if (out_sel !== 2'd2 || out_data !== 8'hA2 || out_valid !== 1'b1)
                begin bad++; $display("FAIL single_out[%0d] got sel=%0d data=%h v=%b exp sel=2 data=a2 v=1", k, out_sel, out_data, out_valid); end
        end
        // Drain with no new request: valid drops, data/sel hold.
        in_valid = 4'h0;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        total++; if (out_sel !== 2'd2 || out_data !== 8'hA2) begin bad++; $display("FAIL drain_hold got sel=%0d data=%h exp sel=2 data=a2", out_sel, out_data); end
    endtask

    task automatic test_mid_reset();
        // Pointer sits at 2, so ch3 loads and is then held.
        in_valid = 4'hF; out_ready = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || out_sel !== 2'd3) begin bad++; $display("FAIL mr_load got v=%b sel=%0d exp v=1 sel=3", out_valid, out_sel); end
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 4'h0) begin bad++; $display("FAIL mr_in_ready got=%b exp=0000", in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%b exp=0", out_valid); end
        rst = 1'b0; out_ready = 1'b1;
        tick();
        total++; if (out_sel !== 2'd0 || out_data !== 8'hA0) begin bad++; $display("FAIL mr_first got sel=%0d data=%h exp sel=0 data=a0", out_sel, out_data); end
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        // Pointer at 0: ch1 wins next, locks for three beats, releases on the fourth.
        in_valid = 4'hF; out_ready = 1'b1; in_lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) in_lock = 4'b0000;
            #1;
            total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL lock_ready[%0d] got=%b exp=0010", k, in_ready); end
            tick();
            total++; if (out_sel !== 2'd1) begin bad++; $display("FAIL lock_sel[%0d] got=%0d exp=1", k, out_sel); end
        end
        tick();
        total++; if (out_sel !== 2'd2) begin bad++; $display("FAIL unlock_sel got=%0d exp=2", out_sel); end
    endtask
`endif

    initial begin
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_single_channel();
        test_mid_reset();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
